// File: rtl/pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_ctrl
// Description : Valid/payload pipeline register chain with per-stage stall,
//               flush and bubble collapse. Optional perf counters under
//               PIPE_STAGE_CTRL_PERF_EN.
// Revision    : 1.0
// ============================================================================
module pipe_stage_ctrl #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall_i,
  input  logic [STAGES-1:0]         flush_i,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_flush_cnt
);

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [STAGES-1:0] w_live;
  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_src_valid;

  assign w_live = r_valid & ~flush_i;

  // Hold propagates from the tail toward stage 0; an empty or flushed
  // stage breaks the chain so upstream items collapse into it.
  always_comb begin
    w_hold = '0;
    w_hold[STAGES-1] = w_live[STAGES-1] & stall_i[STAGES-1];
    for (int k = STAGES-2; k >= 0; k--) begin
      w_hold[k] = w_live[k] & (stall_i[k] | w_hold[k+1]);
    end
  end

  always_comb begin
    w_src_valid = '0;
    w_src_valid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_src_valid[k] = w_live[k-1] & ~w_hold[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush_i[k]) begin
          r_valid[k] <= 1'b0;
        end else if (!w_hold[k]) begin
          r_valid[k] <= w_src_valid[k];
          if (w_src_valid[k]) begin
            r_data[k] <= (k == 0) ? in_data : r_data[(k == 0) ? 0 : k-1];
          end
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_pack
      assign stage_data[g*WIDTH +: WIDTH] = r_data[g];
    end
  endgenerate

  assign in_ready    = ~w_hold[0];
  assign stage_valid = r_valid;
  assign out_valid   = r_valid[STAGES-1];
  assign out_data    = r_data[STAGES-1];

`ifdef PIPE_STAGE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] w_kill_cnt;
  logic [32:0] w_flush_sum;

  always_comb begin
    w_kill_cnt = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_kill_cnt = w_kill_cnt + {31'd0, r_valid[k] & flush_i[k]};
    end
    w_flush_sum = {1'b0, r_flush_cnt} + {1'b0, w_kill_cnt};
  end

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      r_flush_cnt <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule
`default_nettype wire
